// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings and the shadow-pipeline stage record for the forwarding/hazard unit.
package fwd_pkg;

   // Stage records carry rd at a fixed width; REG_AW of any instance must not exceed it.
   localparam int RD_W_MAX = 8;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_EX   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;
   localparam logic [1:0] FWD_WB   = 2'b11;

   typedef struct packed {
      logic                valid;
      logic [RD_W_MAX-1:0] rd;
      logic                we;
      logic                is_load;
   } stage_t;

   function automatic logic stage_hit(input stage_t s, input logic [RD_W_MAX-1:0] rs);
      return s.valid & s.we & (s.rd == rs);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_src_match.sv
// Per-source dependency check: picks the youngest matching producer and flags a load-use hazard.
module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int REG_AW      = 3,
   parameter int FLAG_REG    = 5,
   parameter int ZERO_REG_EN = 0
) (
   input  logic [REG_AW-1:0] rs_i,
   input  stage_t            ex_i,
   input  stage_t            mem_i,
   input  stage_t            wb_i,
   input  logic [DATA_W-1:0] ex_data_i,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              flag_i,
   output logic [1:0]        sel_o,
   output logic [DATA_W-1:0] data_o,
   output logic              load_hit_o
);

   logic [RD_W_MAX-1:0] rs_ext;
   logic                is_flag;
   logic                zero_blk;
   logic                hit_ex;
   logic                hit_mem;
   logic                hit_wb;
   logic                unused_bits;

   assign rs_ext   = RD_W_MAX'(rs_i);
   assign is_flag  = (32'(rs_i) == FLAG_REG);
   assign zero_blk = (ZERO_REG_EN != 0) && (rs_i == '0);

   assign hit_ex  = stage_hit(ex_i, rs_ext) & ~zero_blk;
   assign hit_mem = stage_hit(mem_i, rs_ext) & ~zero_blk;
   assign hit_wb  = stage_hit(wb_i, rs_ext) & ~zero_blk;

   // Only the EX stage can still be waiting on load data.
   assign unused_bits = mem_i.is_load ^ wb_i.is_load;

   always_comb begin
      sel_o  = FWD_NONE;
      data_o = '0;
      if (is_flag) begin
         sel_o  = FWD_WB;
         data_o = DATA_W'(flag_i);
      end else if (hit_ex) begin
         sel_o  = FWD_EX;
         data_o = ex_data_i;
      end else if (hit_mem) begin
         sel_o  = FWD_MEM;
         data_o = mem_data_i;
      end else if (hit_wb) begin
         sel_o  = FWD_WB;
         data_o = wb_data_i;
      end
   end

   assign load_hit_o = hit_ex & ex_i.is_load & ~is_flag;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with its own EX/MEM/WB destination scoreboard and sticky flag.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int REG_AW      = 3,
   parameter int NUM_SRC     = 2,
   parameter int FLAG_REG    = 5,
   parameter int ZERO_REG_EN = 0,
   parameter int CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_we,
   input  logic                      id_is_load,
   input  logic                      flush,
   input  logic [DATA_W-1:0]         ex_data,
   input  logic [DATA_W-1:0]         mem_data,
   input  logic [DATA_W-1:0]         wb_data,
   input  logic                      flag_set,
   input  logic                      flag_clr,
   output logic [NUM_SRC*2-1:0]      fwd_sel,
   output logic [NUM_SRC*DATA_W-1:0] fwd_data,
   output logic                      stall,
   output logic                      flag,
   output logic [CNT_W-1:0]          stall_cnt
);

   stage_t             ex_q, ex_d;
   stage_t             mem_q;
   stage_t             wb_q;
   logic               flag_q, flag_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_SRC-1:0] load_hit;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      fwd_src_match #(
         .DATA_W      (DATA_W),
         .REG_AW      (REG_AW),
         .FLAG_REG    (FLAG_REG),
         .ZERO_REG_EN (ZERO_REG_EN)
      ) u_match (
         .rs_i       (id_rs[g*REG_AW +: REG_AW]),
         .ex_i       (ex_q),
         .mem_i      (mem_q),
         .wb_i       (wb_q),
         .ex_data_i  (ex_data),
         .mem_data_i (mem_data),
         .wb_data_i  (wb_data),
         .flag_i     (flag_q),
         .sel_o      (fwd_sel[g*2 +: 2]),
         .data_o     (fwd_data[g*DATA_W +: DATA_W]),
         .load_hit_o (load_hit[g])
      );
   end

   // A flushed decode slot can never stall, even if it depends on a load.
   assign stall = id_valid & ~flush & (|load_hit);

   always_comb begin
      ex_d         = '0;
      ex_d.valid   = id_valid & ~flush & ~stall;
      ex_d.rd      = RD_W_MAX'(id_rd);
      ex_d.we      = id_we;
      ex_d.is_load = id_is_load;
   end

   always_comb begin
      flag_d = flag_q;
      if (flag_clr) begin
         flag_d = 1'b0;
      end else if (flag_set) begin
         flag_d = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q   <= '0;
         mem_q  <= '0;
         wb_q   <= '0;
         flag_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         ex_q   <= ex_d;
         mem_q  <= ex_q;
         wb_q   <= mem_q;
         flag_q <= flag_d;
         cnt_q  <= cnt_d;
      end
   end

   assign flag      = flag_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: scoreboard model of the producer stages plus literal checkpoints.
module tb_fwd_hazard_unit;
   import fwd_pkg::*;

   localparam int DW = 8;
   localparam int AW = 3;
   localparam int NS = 2;
   localparam int FR = 5;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           id_valid = 1'b0;
   logic [NS*AW-1:0] id_rs = '0;
   logic [AW-1:0]  id_rd = '0;
   logic           id_we = 1'b0;
   logic           id_is_load = 1'b0;
   logic           flush = 1'b0;
   logic [DW-1:0]  ex_data = '0;
   logic [DW-1:0]  mem_data = '0;
   logic [DW-1:0]  wb_data = '0;
   logic           flag_set = 1'b0;
   logic           flag_clr = 1'b0;

   logic [NS*2-1:0]  fwd_sel;
   logic [NS*DW-1:0] fwd_data;
   logic             stall;
   logic             flag;
   logic [15:0]      stall_cnt;

   logic [NS*2-1:0]  z_sel;
   logic [NS*DW-1:0] z_data;
   logic             z_stall;
   logic             z_flag;
   logic [1:0]       z_cnt;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] p_ex = '0;
   logic [DW-1:0] p_mem = '0;
   logic [DW-1:0] p_wb = '0;

   // Model: what entered EX on each of the last three cycles (index 0 = EX, 1 = MEM, 2 = WB).
   bit m_v[3];
   int m_rd[3];
   bit m_we[3];
   bit m_ld[3];
   bit m_flag;
   int m_cnt;

   fwd_hazard_unit #(
      .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .FLAG_REG(FR), .ZERO_REG_EN(0), .CNT_W(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .ex_data(ex_data),
      .mem_data(mem_data), .wb_data(wb_data), .flag_set(flag_set), .flag_clr(flag_clr),
      .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall(stall), .flag(flag), .stall_cnt(stall_cnt)
   );

   fwd_hazard_unit #(
      .DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .FLAG_REG(FR), .ZERO_REG_EN(1), .CNT_W(2)
   ) dut_z (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
      .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .ex_data(ex_data),
      .mem_data(mem_data), .wb_data(wb_data), .flag_set(flag_set), .flag_clr(flag_clr),
      .fwd_sel(z_sel), .fwd_data(z_data), .stall(z_stall), .flag(z_flag), .stall_cnt(z_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int exp_sel(input int rs);
      if (rs == FR) return 3;
      for (int s = 0; s < 3; s++)
         if (m_v[s] && m_we[s] && m_rd[s] == rs) return s + 1;
      return 0;
   endfunction

   function automatic int exp_data(input int rs);
      if (rs == FR) return int'(m_flag);
      case (exp_sel(rs))
         1: return int'(ex_data);
         2: return int'(mem_data);
         3: return int'(wb_data);
         default: return 0;
      endcase
   endfunction

   function automatic bit exp_stall();
      if (!id_valid || flush) return 1'b0;
      for (int i = 0; i < NS; i++) begin
         int rs;
         rs = int'(id_rs[i*AW +: AW]);
         if (rs != FR && m_v[0] && m_we[0] && m_ld[0] && m_rd[0] == rs) return 1'b1;
      end
      return 1'b0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < 3; s++) m_v[s] <= 1'b0;
         m_flag <= 1'b0;
         m_cnt  <= 0;
      end else begin
         m_v[2]  <= m_v[1];  m_rd[2] <= m_rd[1];  m_we[2] <= m_we[1];  m_ld[2] <= m_ld[1];
         m_v[1]  <= m_v[0];  m_rd[1] <= m_rd[0];  m_we[1] <= m_we[0];  m_ld[1] <= m_ld[0];
         m_v[0]  <= id_valid && !flush && !exp_stall();
         m_rd[0] <= int'(id_rd);
         m_we[0] <= id_we;
         m_ld[0] <= id_is_load;
         m_flag  <= flag_clr ? 1'b0 : (flag_set ? 1'b1 : m_flag);
         m_cnt   <= (exp_stall() && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      end
   end

   always @(negedge clk) begin
      #4;
      if (rst_n && chk_en) begin
         for (int i = 0; i < NS; i++) begin
            int rs;
            rs = int'(id_rs[i*AW +: AW]);
            chk($sformatf("model_sel%0d", i), 32'(fwd_sel[i*2 +: 2]), exp_sel(rs));
            chk($sformatf("model_data%0d", i), 32'(fwd_data[i*DW +: DW]), exp_data(rs));
         end
         chk("model_stall", 32'(stall), 32'(exp_stall()));
         chk("model_flag", 32'(flag), 32'(m_flag));
         chk("model_cnt", 32'(stall_cnt), m_cnt);
      end
   end

   task automatic set_dec(input bit v, input int r0, input int r1, input int rd,
                          input bit we, input bit ld);
      id_valid   = v;
      id_rs      = {3'(r1), 3'(r0)};
      id_rd      = 3'(rd);
      id_we      = we;
      id_is_load = ld;
      ex_data    = p_ex;
      mem_data   = p_mem;
      wb_data    = p_wb;
   endtask

   task automatic apply(input bit v, input int r0, input int r1, input int rd, input bit we,
                        input bit ld, input bit fl = 1'b0, input bit fs = 1'b0, input bit fc = 1'b0);
      @(negedge clk);
      set_dec(v, r0, r1, rd, we, ld);
      flush    = fl;
      flag_set = fs;
      flag_clr = fc;
      #4;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) apply(1'b0, 6, 7, 0, 1'b0, 1'b0);
   endtask

   task automatic set_data(input logic [DW-1:0] e, input logic [DW-1:0] m, input logic [DW-1:0] w);
      p_ex  = e;
      p_mem = m;
      p_wb  = w;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #4;
      chk("rst_sel", 32'(fwd_sel), 0);
      chk("rst_data", 32'(fwd_data), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_cnt", 32'(stall_cnt), 0);
      chk_en = 1'b1;

      // Mid-stream reset with a load in EX and the flag being set.
      apply(1, 6, 7, 1, 1, 1);
      apply(1, 1, 6, 3, 1, 0, 0, 1);
      chk("pre_rst_stall", 32'(stall), 1);
      chk("pre_rst_sel", 32'(fwd_sel[1:0]), 32'(FWD_EX));
      @(negedge clk);
      rst_n = 1'b0;
      set_dec(1, 1, 6, 3, 0, 0);
      flag_set = 1'b0;
      #4;
      chk("in_rst_stall", 32'(stall), 0);
      chk("in_rst_sel", 32'(fwd_sel), 0);
      chk("in_rst_flag", 32'(flag), 0);
      chk("in_rst_cnt", 32'(stall_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #4;
      chk("post_rst_sel", 32'(fwd_sel), 0);
      chk("post_rst_data", 32'(fwd_data), 0);
      chk("post_rst_stall", 32'(stall), 0);
      idle(3);

      // ALU chain.
      set_data(8'h3C, 8'h00, 8'h00);
      apply(1, 6, 7, 2, 1, 0);
      apply(1, 2, 2, 3, 1, 0);
      chk("alu_sel", 32'(fwd_sel), 32'({FWD_EX, FWD_EX}));
      chk("alu_data", 32'(fwd_data), 32'h3C3C);
      chk("alu_stall", 32'(stall), 0);
      set_data(8'h00, 8'h3C, 8'h00);
      apply(1, 2, 6, 7, 0, 0);
      chk("alu_mem_sel", 32'(fwd_sel), 32'({FWD_NONE, FWD_MEM}));
      chk("alu_mem_data", 32'(fwd_data), 32'h003C);
      idle(3);

      // MEM beats WB for the same register.
      set_data(8'h00, 8'h11, 8'h22);
      apply(1, 6, 7, 4, 1, 0);
      apply(1, 6, 7, 4, 1, 0);
      apply(1, 6, 7, 0, 0, 0);
      apply(1, 4, 6, 0, 0, 0);
      chk("prio_mem_sel", 32'(fwd_sel[1:0]), 32'(FWD_MEM));
      chk("prio_mem_data", 32'(fwd_data[7:0]), 32'h11);
      apply(1, 4, 6, 0, 0, 0);
      chk("prio_wb_sel", 32'(fwd_sel[1:0]), 32'(FWD_WB));
      chk("prio_wb_data", 32'(fwd_data[7:0]), 32'h22);
      idle(3);

      // Load-use: one stall cycle, then the load resolves from MEM.
      set_data(8'h00, 8'hA5, 8'h00);
      apply(1, 6, 7, 1, 1, 1);
      apply(1, 1, 6, 3, 1, 0);
      chk("lu_stall", 32'(stall), 1);
      apply(1, 1, 6, 3, 1, 0);
      chk("lu_stall_end", 32'(stall), 0);
      chk("lu_sel", 32'(fwd_sel[1:0]), 32'(FWD_MEM));
      chk("lu_data", 32'(fwd_data[7:0]), 32'hA5);
      chk("lu_cnt", 32'(stall_cnt), 1);
      idle(3);

      // Flag overrides a pending load to the same address and never stalls.
      set_data(8'h77, 8'h00, 8'h00);
      apply(1, 6, 7, 5, 1, 1, 0, 1);
      apply(1, 5, 5, 0, 0, 0);
      chk("flag_sel", 32'(fwd_sel), 32'({FWD_WB, FWD_WB}));
      chk("flag_data", 32'(fwd_data), 32'h0101);
      chk("flag_stall", 32'(stall), 0);
      chk("flag_q", 32'(flag), 1);
      apply(1, 6, 7, 0, 0, 0, 0, 1, 1);
      apply(1, 5, 6, 0, 0, 0);
      chk("flag_clr", 32'(flag), 0);
      chk("flag_clr_data", 32'(fwd_data[7:0]), 0);
      idle(3);

      // Flush squashes a dependent instruction; EX takes a bubble.
      set_data(8'h00, 8'h5C, 8'h00);
      apply(1, 6, 7, 1, 1, 1);
      apply(1, 1, 6, 3, 1, 0, 1);
      chk("flush_stall", 32'(stall), 0);
      apply(1, 1, 3, 0, 0, 0);
      chk("flush_sel", 32'(fwd_sel), 32'({FWD_NONE, FWD_MEM}));
      chk("flush_data", 32'(fwd_data[7:0]), 32'h5C);
      idle(3);

      // Zero register: forwarded normally, suppressed when ZERO_REG_EN=1.
      set_data(8'h5A, 8'h00, 8'h00);
      apply(1, 6, 7, 0, 1, 0);
      apply(1, 0, 6, 1, 0, 0);
      chk("zero_sel_off", 32'(fwd_sel[1:0]), 32'(FWD_EX));
      chk("zero_data_off", 32'(fwd_data[7:0]), 32'h5A);
      chk("zero_sel_on", 32'(z_sel[1:0]), 32'(FWD_NONE));
      chk("zero_data_on", 32'(z_data[7:0]), 0);
      idle(3);

      // Three more load-use stalls: the 2-bit counter pins at all-ones.
      for (int k = 0; k < 3; k++) begin
         apply(1, 6, 7, 2, 1, 1);
         apply(1, 6, 2, 3, 0, 0);
         apply(1, 6, 2, 3, 0, 0);
      end
      chk("cnt_total", 32'(stall_cnt), 4);
      chk("cnt_sat", 32'(z_cnt), 3);
      idle(2);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
